// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus GPIO, timer and status MMIO.
// Ports: clk/rst (sync, active-low), core MemRead/MemWrite/RWAddress/
//   WriteData -> MemData (combinational), gpio_in/gpio_out, irq, addr_err.
module data_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RAM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] MemData,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  irq,
    output logic                  addr_err
);

    localparam int IDX_W = $clog2(RAM_DEPTH);

    localparam logic [DATA_WIDTH-1:0] RAM_BYTES = DATA_WIDTH'(4 * RAM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] OFS_GOUT  = DATA_WIDTH'(32'h400);
    localparam logic [DATA_WIDTH-1:0] OFS_GIN   = DATA_WIDTH'(32'h404);
    localparam logic [DATA_WIDTH-1:0] OFS_CNT   = DATA_WIDTH'(32'h408);
    localparam logic [DATA_WIDTH-1:0] OFS_CMP   = DATA_WIDTH'(32'h40C);
    localparam logic [DATA_WIDTH-1:0] OFS_CTRL  = DATA_WIDTH'(32'h410);
    localparam logic [DATA_WIDTH-1:0] OFS_STAT  = DATA_WIDTH'(32'h414);

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] gpioOut;
    logic [DATA_WIDTH-1:0] gpioSync1;
    logic [DATA_WIDTH-1:0] gpioSync2;
    logic [DATA_WIDTH-1:0] tmrCnt;
    logic [DATA_WIDTH-1:0] tmrCmp;
    logic [1:0]            tmrCtrl;
    logic                  status;
    logic                  addrErr;

    logic [DATA_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      ramIdx;
    logic                  aligned;
    logic                  hitRam;
    logic                  hitGout;
    logic                  hitGin;
    logic                  hitCnt;
    logic                  hitCmp;
    logic                  hitCtrl;
    logic                  hitStat;
    logic                  mapped;
    logic                  badAccess;
    logic                  wrOk;
    logic                  matchNow;
    logic [DATA_WIDTH-1:0] rdData;

    // Addresses below BASE_ADDR wrap to huge offsets and fall out as unmapped.
    assign offset  = RWAddress - BASE_ADDR;
    assign ramIdx  = offset[IDX_W+1:2];
    assign aligned = (RWAddress[1:0] == 2'b00);

    assign hitRam  = aligned && (offset < RAM_BYTES);
    assign hitGout = aligned && (offset == OFS_GOUT);
    assign hitGin  = aligned && (offset == OFS_GIN);
    assign hitCnt  = aligned && (offset == OFS_CNT);
    assign hitCmp  = aligned && (offset == OFS_CMP);
    assign hitCtrl = aligned && (offset == OFS_CTRL);
    assign hitStat = aligned && (offset == OFS_STAT);

    assign mapped = hitRam | hitGout | hitGin | hitCnt |
                    hitCmp | hitCtrl | hitStat;

    // GPIO_IN is read-only, so a store to it is treated as a bad access.
    assign badAccess = (MemRead | MemWrite) &
                       (~mapped | (MemWrite & hitGin));

    // Writes are suppressed while reset is held so nothing commits.
    assign wrOk = MemWrite & ~badAccess & rst;

    assign matchNow = tmrCtrl[0] && (tmrCnt == tmrCmp);

    always_comb begin
        rdData = '0;
        unique case (1'b1)
            hitRam:  rdData = ram[ramIdx];
            hitGout: rdData = gpioOut;
            hitGin:  rdData = gpioSync2;
            hitCnt:  rdData = tmrCnt;
            hitCmp:  rdData = tmrCmp;
            hitCtrl: rdData = {{(DATA_WIDTH-2){1'b0}}, tmrCtrl};
            hitStat: rdData = {{(DATA_WIDTH-1){1'b0}}, status};
            default: rdData = '0;
        endcase
    end

    // Pre-write value is returned because state only changes on the edge.
    assign MemData = MemRead ? rdData : '0;

    always_ff @(posedge clk) begin
        if (wrOk && hitRam) begin
            ram[ramIdx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gpioOut   <= '0;
            gpioSync1 <= '0;
            gpioSync2 <= '0;
            tmrCnt    <= '0;
            tmrCmp    <= '1;
            tmrCtrl   <= 2'b00;
            status    <= 1'b0;
            addrErr   <= 1'b0;
        end else begin
            gpioSync1 <= gpio_in;
            gpioSync2 <= gpioSync1;
            addrErr   <= badAccess;

            if (wrOk && hitGout) begin
                gpioOut <= WriteData;
            end

            // A core write to the counter beats the increment.
            if (wrOk && hitCnt) begin
                tmrCnt <= WriteData;
            end else if (tmrCtrl[0]) begin
                tmrCnt <= tmrCnt + DATA_WIDTH'(1);
            end

            if (wrOk && hitCmp) begin
                tmrCmp <= WriteData;
            end

            if (wrOk && hitCtrl) begin
                tmrCtrl <= WriteData[1:0];
            end

            // A fresh match outranks a coincident write-1-to-clear.
            if (matchNow) begin
                status <= 1'b1;
            end else if (wrOk && hitStat && WriteData[0]) begin
                status <= 1'b0;
            end
        end
    end

    assign gpio_out = gpioOut;
    assign addr_err = addrErr;
    assign irq      = status & tmrCtrl[1];

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter RAM_DEPTH, default 256, data RAM size in words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1001_0000, first byte address of data RAM.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port MemRead  input  1  core read strobe for the current cycle.
REQ-007 SHALL have port MemWrite  input  1  core write strobe for the current cycle.
REQ-008 SHALL have port RWAddress  input  DATA_WIDTH  byte address from the core.
REQ-009 SHALL have port WriteData  input  DATA_WIDTH  store data from the core.
REQ-010 SHALL have port MemData  output  DATA_WIDTH  load data returned to the core.
REQ-011 SHALL have port gpio_in  input  DATA_WIDTH  asynchronous external input pins.
REQ-012 SHALL have port gpio_out  output  DATA_WIDTH  registered output pins.
REQ-013 SHALL have port irq  output  1  timer interrupt request.
REQ-014 SHALL have port addr_err  output  1  one-cycle pulse on a bad access.

Function
REQ-015 Address map, all offsets from BASE_ADDR:
- RAM: 0x000 to 4*RAM_DEPTH-1.
- MMIO at 0x400 + n:
  - GPIO_OUT 0x400, RW.
  - GPIO_IN 0x404, RO.
  - TMR_CNT 0x408, RW.
  - TMR_CMP 0x40C, RW.
  - TMR_CTRL 0x410, RW; bit0 enable, bit1 irq_en.
  - STATUS 0x414; bit0 match, write-1-to-clear.
REQ-016 Reads SHALL be combinational: MemData valid in the same cycle MemRead and RWAddress are presented, zero-cycle latency.
REQ-017 MemData SHALL be 0 when MemRead is low, or when the address is unmapped or misaligned.
REQ-018 Writes SHALL commit on the rising edge where MemWrite=1; the new value SHALL be readable from the following cycle.
REQ-019 MemRead=1 and MemWrite=1 together: the read SHALL return the pre-write value, and the write SHALL commit.
REQ-020 Unmapped address, misaligned address (RWAddress[1:0]!=0), or write to GPIO_IN, with MemRead or MemWrite high:
- no state change;
- addr_err=1 for the next cycle only.
REQ-021 gpio_in SHALL pass through a 2-flop synchronizer; a GPIO_IN read returns the second-stage value (2-cycle input latency).
REQ-022 TMR_CNT SHALL increment by 1 each cycle while TMR_CTRL.enable=1, wrapping 0xFFFFFFFF -> 0.
REQ-023 A core write to TMR_CNT in the same cycle as an increment: the written value SHALL win.
REQ-024 STATUS.match SHALL set on the edge following any cycle with enable=1 and TMR_CNT==TMR_CMP.
REQ-025 W1C write to STATUS coinciding with a new match: set SHALL win.
REQ-026 irq SHALL equal STATUS.match AND TMR_CTRL.irq_en, registered-state only (no combinational path from core inputs).
REQ-027 Register bits beyond those defined SHALL read 0 and ignore writes.

Reset
REQ-028 On rising edge with rst=0, SHALL clear:
- gpio_out, TMR_CNT, TMR_CTRL, STATUS and synchronizer flops to 0;
- TMR_CMP to 0xFFFFFFFF;
- addr_err and irq to 0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-access SHALL override: a write presented in the reset cycle SHALL NOT commit to any MMIO register.

Verification
REQ-031 Store/load RAM:
- write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 next cycle -> MemData=0xDEADBEEF.
- same-cycle read of BASE+0x10 with a write of 0x1 -> returns old 0xDEADBEEF.
REQ-032 Bad addresses:
- read BASE+0x2 -> MemData=0, addr_err pulses exactly one cycle, RAM unchanged.
- write BASE+0x800 -> MemData=0, addr_err pulses exactly one cycle, RAM unchanged.
REQ-033 Timer match:
- write TMR_CMP=5, TMR_CTRL=0x3 -> STATUS.match=1 and irq=1 on the edge after the count is 5.
- write STATUS=1 -> irq=0 the next cycle.
REQ-034 Timer wrap and write priority:
- with TMR_CNT=0xFFFFFFFF and enable=1 -> next cycle reads 0.
- write TMR_CNT=0x100 while enabled -> reads 0x100, not 0x101, next cycle.
REQ-035 GPIO:
- gpio_in changes to 0xA5 -> GPIO_IN read shows 0xA5 no earlier than 2 cycles later.
- write GPIO_OUT=0x3C -> gpio_out=0x3C after the edge.
REQ-036 Reset mid-operation: rst=0 while a write to GPIO_OUT=0xFF is presented -> gpio_out=0, TMR_CMP reads 0xFFFFFFFF, RAM data retained.
